dmem_arbiter: RTL and testbench

- Shares the single-port 64-word data memory between two requesters.
- Port A is the pipeline MEM stage. Port B is the loader/debug port that fills or inspects data memory while the core runs.
- The block issues at most one access per cycle and gives port A fixed priority. A starvation counter guarantees port B progress.
- It drives the memory's addr, wr_en and wr_data pins, and returns registered read data to the winning port.

---
 rtl/dmem_arb_pkg.sv | 13 +
 rtl/arb_starve_ctr.sv | 28 ++
 rtl/dmem_arbiter.sv | 102 ++++++++++
 tb/tb_dmem_arbiter.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared constants and winner encoding for the data-memory arbiter.
// Imported by dmem_arbiter and arb_starve_ctr.
package dmem_arb_pkg;
  localparam int DMEM_ADDR_W  = 6;
  localparam int DMEM_DEPTH   = 64;
  localparam int STARVE_CNT_W = 4;

  typedef enum logic [1:0] {
    ARB_NONE,
    ARB_A,
    ARB_B
  } arb_win_e;
endpackage

// File: rtl/arb_starve_ctr.sv
// Saturating count of consecutive cycles port B has been refused.
// at_limit flags that B must be force-granted.
module arb_starve_ctr
  import dmem_arb_pkg::*;
#(
  parameter int MAX_WAIT = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    inc,
  input  logic                    clr,
  output logic [STARVE_CNT_W-1:0] count,
  output logic                    at_limit
);
  localparam logic [STARVE_CNT_W-1:0] LIMIT = STARVE_CNT_W'(MAX_WAIT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != LIMIT)) begin
      count <= count + 1'b1;
    end
  end

  assign at_limit = (count == LIMIT);
endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter for the single-port data memory: port A has fixed priority,
// port B is force-granted after MAX_WAIT consecutive refusals.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int WORDLENGHT = 32,
  parameter int MAX_WAIT   = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   a_req,
  input  logic                   a_we,
  input  logic [DMEM_ADDR_W-1:0] a_addr,
  input  logic [WORDLENGHT-1:0]  a_wdata,
  output logic                   a_ack,
  output logic [WORDLENGHT-1:0]  a_rdata,
  output logic                   a_rvalid,
  input  logic                   b_req,
  input  logic                   b_we,
  input  logic [DMEM_ADDR_W-1:0] b_addr,
  input  logic [WORDLENGHT-1:0]  b_wdata,
  output logic                   b_ack,
  output logic [WORDLENGHT-1:0]  b_rdata,
  output logic                   b_rvalid,
  output logic [DMEM_ADDR_W-1:0] mem_addr,
  output logic                   mem_wr_en,
  output logic [WORDLENGHT-1:0]  mem_wr_data,
  input  logic [WORDLENGHT-1:0]  mem_rd_data,
  output logic                   b_starved
);
  arb_win_e                  win;
  logic                      at_limit;
  logic                      starve_hit;
  logic                      a_rd;
  logic                      b_rd;
  logic [STARVE_CNT_W-1:0]   wait_cnt_unused;

  arb_starve_ctr #(
    .MAX_WAIT(MAX_WAIT)
  ) u_ctr (
    .clk     (clk),
    .rst     (rst),
    .inc     (b_req && !b_ack),
    .clr     (b_ack || !b_req),
    .count   (wait_cnt_unused),
    .at_limit(at_limit)
  );

  assign starve_hit = at_limit && b_req;

  // Nothing may reach the memory while reset is held, so the winner is forced to none.
  always_comb begin
    win = ARB_NONE;
    if (!rst) begin
      win = ARB_NONE;
    end else if (starve_hit || (b_req && !a_req)) begin
      win = ARB_B;
    end else if (a_req) begin
      win = ARB_A;
    end
  end

  always_comb begin
    a_ack       = (win == ARB_A);
    b_ack       = (win == ARB_B);
    b_starved   = rst && starve_hit;
    mem_addr    = rst ? a_addr : '0;
    mem_wr_en   = 1'b0;
    mem_wr_data = '0;
    case (win)
      ARB_A: begin
        mem_addr    = a_addr;
        mem_wr_en   = a_we;
        mem_wr_data = a_wdata;
      end
      ARB_B: begin
        mem_addr    = b_addr;
        mem_wr_en   = b_we;
        mem_wr_data = b_wdata;
      end
      default: ;
    endcase
  end

  assign a_rd = (win == ARB_A) && !a_we;
  assign b_rd = (win == ARB_B) && !b_we;

  // rdata is only refreshed by a read to its own port; rvalid is a one-cycle pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
      a_rdata  <= '0;
      b_rdata  <= '0;
    end else begin
      a_rvalid <= a_rd;
      b_rvalid <= b_rd;
      if (a_rd) a_rdata <= mem_rd_data;
      if (b_rd) b_rdata <= mem_rd_data;
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural 64-word memory and a
// read-data scoreboard popped by an independent monitor.
module tb_dmem_arbiter;
  logic        clk;
  logic        rst;
  logic        a_req, a_we, b_req, b_we;
  logic [5:0]  a_addr, b_addr, mem_addr;
  logic [31:0] a_wdata, b_wdata, a_rdata, b_rdata, mem_wr_data, mem_rd_data;
  logic        a_ack, b_ack, a_rvalid, b_rvalid, mem_wr_en, b_starved;

  logic [31:0] mem [64];
  logic [31:0] exp_a_q[$];
  logic [31:0] exp_b_q[$];
  int          total = 0;
  int          bad   = 0;

  dmem_arbiter #(.WORDLENGHT(32), .MAX_WAIT(4)) dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_ack(a_ack), .a_rdata(a_rdata), .a_rvalid(a_rvalid),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_ack(b_ack), .b_rdata(b_rdata), .b_rvalid(b_rvalid),
    .mem_addr(mem_addr), .mem_wr_en(mem_wr_en), .mem_wr_data(mem_wr_data),
    .mem_rd_data(mem_rd_data), .b_starved(b_starved)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: combinational read, write committed at the rising edge.
  assign mem_rd_data = mem[mem_addr];
  always @(posedge clk) if (mem_wr_en) mem[mem_addr] <= mem_wr_data;

  // Monitor: every rvalid pulse must match the oldest expected read for that port.
  always @(negedge clk) begin
    logic [31:0] e;
    if (a_rvalid) begin
      total++;
      if (exp_a_q.size() == 0) begin
        bad++;
        $display("[TB] FAIL a_rvalid_unexpected: got a_rdata=%h, required no rvalid", a_rdata);
      end else begin
        e = exp_a_q.pop_front();
        if (a_rdata !== e) begin
          bad++;
          $display("[TB] FAIL a_rdata: got %h, required %h", a_rdata, e);
        end
      end
    end
    if (b_rvalid) begin
      total++;
      if (exp_b_q.size() == 0) begin
        bad++;
        $display("[TB] FAIL b_rvalid_unexpected: got b_rdata=%h, required no rvalid", b_rdata);
      end else begin
        e = exp_b_q.pop_front();
        if (b_rdata !== e) begin
          bad++;
          $display("[TB] FAIL b_rdata: got %h, required %h", b_rdata, e);
        end
      end
    end
  end

  task automatic applyStimulus(input logic ar, input logic aw, input logic [5:0] aa,
                               input logic [31:0] ad, input logic br, input logic bw,
                               input logic [5:0] ba, input logic [31:0] bd);
    a_req = ar; a_we = aw; a_addr = aa; a_wdata = ad;
    b_req = br; b_we = bw; b_addr = ba; b_wdata = bd;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Waits for the falling edge, then compares {a_ack, b_ack, mem_wr_en, b_starved}.
  task automatic checkOutput(input string name, input logic ea, input logic eb,
                             input logic ew, input logic es);
    logic [3:0] act, req;
    @(negedge clk);
    act = {a_ack, b_ack, mem_wr_en, b_starved};
    req = {ea, eb, ew, es};
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s: got ack_a/ack_b/wr_en/starved=%b, required %b", name, act, req);
    end
  endtask

  task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    mem[0] = 32'hA0; mem[1] = 32'hA1; mem[2] = 32'hA2;

    // Reset held with A trying to write: nothing may leak to the memory pins.
    rst = 1'b0;
    applyStimulus(1, 1, 6'd20, 32'h55, 0, 0, 6'd0, 32'h0);
    checkOutput("reset_acks", 0, 0, 0, 0);
    checkValue("reset_mem_addr", 32'(mem_addr), 32'h0);
    checkValue("reset_mem_wr_data", mem_wr_data, 32'h0);
    checkValue("reset_rvalid", {30'h0, a_rvalid, b_rvalid}, 32'h0);
    checkValue("reset_a_rdata", a_rdata, 32'h0);
    checkValue("reset_b_rdata", b_rdata, 32'h0);
    step();
    step();
    checkValue("reset_no_write", mem[20], 32'h0);
    applyStimulus(0, 0, 6'd0, 32'h0, 0, 0, 6'd0, 32'h0);
    rst = 1'b1;

    for (int c = 0; c < 10; c++) begin
      checkOutput("idle", 0, 0, 0, 0);
      step();
    end

    applyStimulus(1, 1, 6'd5, 32'hDEADBEEF, 0, 0, 6'd0, 32'h0);
    checkOutput("a_write", 1, 0, 1, 0);
    checkValue("a_write_addr", 32'(mem_addr), 32'd5);
    checkValue("a_write_data", mem_wr_data, 32'hDEADBEEF);
    step();
    applyStimulus(1, 0, 6'd5, 32'h0, 0, 0, 6'd0, 32'h0);
    checkOutput("a_read", 1, 0, 0, 0);
    exp_a_q.push_back(32'hDEADBEEF);
    step();
    applyStimulus(0, 0, 6'd0, 32'h0, 0, 0, 6'd0, 32'h0);
    checkOutput("after_read", 0, 0, 0, 0);
    step();

    // Both ports reading continuously: A,A,A,A then starved B, repeating.
    applyStimulus(1, 0, 6'd1, 32'h0, 1, 0, 6'd2, 32'h0);
    for (int c = 0; c < 10; c++) begin
      logic eb;
      eb = ((c % 5) == 4);
      checkOutput("contend", !eb, eb, 0, eb);
      if (eb) exp_b_q.push_back(32'hA2);
      else    exp_a_q.push_back(32'hA1);
      step();
    end
    applyStimulus(0, 0, 6'd0, 32'h0, 0, 0, 6'd0, 32'h0);
    checkOutput("contend_drain", 0, 0, 0, 0);
    step();

    // Same address: A's write lands first, B's read then sees it.
    applyStimulus(1, 1, 6'd9, 32'h11, 1, 0, 6'd9, 32'h0);
    checkOutput("same_addr_a", 1, 0, 1, 0);
    step();
    applyStimulus(0, 0, 6'd0, 32'h0, 1, 0, 6'd9, 32'h0);
    checkOutput("same_addr_b", 0, 1, 0, 0);
    exp_b_q.push_back(32'h11);
    step();

    for (int c = 0; c < 3; c++) begin
      applyStimulus(0, 0, 6'd0, 32'h0, 1, 0, 6'(c), 32'h0);
      checkOutput("b_b2b", 0, 1, 0, 0);
      exp_b_q.push_back(32'hA0 + 32'(c));
      step();
    end
    applyStimulus(0, 0, 6'd0, 32'h0, 0, 0, 6'd0, 32'h0);
    checkOutput("b_b2b_drain", 0, 0, 0, 0);
    step();
    checkOutput("idle2", 0, 0, 0, 0);
    step();

    // Reset between the read issue edge and its rvalid cycle.
    applyStimulus(1, 0, 6'd5, 32'h0, 1, 0, 6'd0, 32'h0);
    checkOutput("mid_c1", 1, 0, 0, 0);
    exp_a_q.push_back(32'hDEADBEEF);
    step();
    checkOutput("mid_c2", 1, 0, 0, 0);
    step();
    rst = 1'b0;
    #1;
    checkValue("mid_rst_a_rvalid", {31'h0, a_rvalid}, 32'h0);
    checkValue("mid_rst_a_rdata", a_rdata, 32'h0);
    checkValue("mid_rst_acks", {30'h0, a_ack, b_ack}, 32'h0);
    step();
    rst = 1'b1;
    for (int c = 0; c < 5; c++) begin
      logic eb;
      eb = (c == 4);
      checkOutput("post_rst_contend", !eb, eb, 0, eb);
      if (eb) exp_b_q.push_back(32'hA0);
      else    exp_a_q.push_back(32'hDEADBEEF);
      step();
    end
    applyStimulus(0, 0, 6'd0, 32'h0, 0, 0, 6'd0, 32'h0);
    checkOutput("final_idle", 0, 0, 0, 0);
    step();
    checkOutput("final_idle2", 0, 0, 0, 0);
    step();

    checkValue("a_reads_outstanding", 32'(exp_a_q.size()), 32'h0);
    checkValue("b_reads_outstanding", 32'(exp_b_q.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
